// File: rtl/dmem_ctrl.sv
// Word-organised data RAM controller with a valid/ready request/response port,
// RISC-V byte/half/word access, wait states, post-reset clear sweep and error responses.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W     = 4;
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  clr_idx;
  logic [CNT_W-1:0]  wcnt;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              lat_we, lat_unsigned;
  logic [1:0]        lat_size;
  logic [31:0]       lat_addr, lat_wdata;

  logic              cur_we, cur_unsigned;
  logic [1:0]        cur_size;
  logic [31:0]       cur_addr, cur_wdata;
  logic [32:0]       offset;
  logic [IDX_W-1:0]  widx;
  logic [1:0]        lane;
  logic              err;
  logic [31:0]       rword, ld_data, wd;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [3:0]        be;
  logic              acc_fire, do_write;

  // Access fields come straight from the port on the handshake edge, from the latch afterwards.
  always_comb begin
    cur_we       = lat_we;
    cur_unsigned = lat_unsigned;
    cur_size     = lat_size;
    cur_addr     = lat_addr;
    cur_wdata    = lat_wdata;
    if (state == S_IDLE) begin
      cur_we       = req_we;
      cur_unsigned = req_unsigned;
      cur_size     = req_size;
      cur_addr     = req_addr;
      cur_wdata    = req_wdata;
    end
  end

  // Address decode, error detection, load extraction and store lane steering.
  always_comb begin
    offset  = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    widx    = offset[IDX_W+1:2];
    lane    = cur_addr[1:0];
    err     = (cur_size == 2'd3)
            | ((cur_size == 2'd1) & cur_addr[0])
            | ((cur_size == 2'd2) & (|cur_addr[1:0]))
            | (offset >= SPAN);
    rword   = mem[widx];
    rbyte   = rword[{lane, 3'b000} +: 8];
    rhalf   = cur_addr[1] ? rword[31:16] : rword[15:0];
    ld_data = rword;
    be      = 4'b0000;
    wd      = cur_wdata;
    case (cur_size)
      2'd0: begin
        ld_data = cur_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
        be      = 4'b0001 << lane;
        wd      = {4{cur_wdata[7:0]}};
      end
      2'd1: begin
        ld_data = cur_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
        be      = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd      = {2{cur_wdata[15:0]}};
      end
      2'd2: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    acc_fire = (state_d == S_RESP) && (state != S_RESP);
    do_write = acc_fire && cur_we && !err;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      S_CLEAR: if (clr_idx == LAST) state_d = S_IDLE;
      S_IDLE:  if (req_valid) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wcnt == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_CLEAR;
      clr_idx      <= '0;
      wcnt         <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      state     <= state_d;
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RESP);
      if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
      if (state == S_IDLE && req_valid) begin
        lat_we       <= req_we;
        lat_unsigned <= req_unsigned;
        lat_size     <= req_size;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
        wcnt         <= WAIT_LOAD;
      end else if (state == S_WAIT && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end
      if (acc_fire) begin
        rsp_rdata <= (cur_we || err) ? 32'h0 : ld_data;
        rsp_err   <= err;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // RAM array: clear sweep has priority; stores commit only on the RESP entry edge.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: one zero-wait instance for functional
// accesses and one three-wait instance for latency, back-pressure and mid-access reset.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_valid0, req_valid3, rsp_ready0, rsp_ready3;
  logic        req_ready0, req_ready3, rsp_valid0, rsp_valid3, rsp_err0, rsp_err3;
  logic [31:0] rsp_rdata0, rsp_rdata3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete request/response on the selected instance, ready held high for the response.
  task automatic xact(input int sel, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int n;
    n = 0;
    while (((sel == 0) ? req_ready0 : req_ready3) !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "/ready_timeout"}, 32'(n >= 200), 32'd0);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (sel == 0) req_valid0 = 1'b1; else req_valid3 = 1'b1;
    step();
    req_valid0 = 1'b0;
    req_valid3 = 1'b0;
    n = 0;
    while (((sel == 0) ? rsp_valid0 : rsp_valid3) !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({tag, "/rsp_timeout"}, 32'(n >= 50), 32'd0);
    chk({tag, "/rdata"}, (sel == 0) ? rsp_rdata0 : rsp_rdata3, exp_rdata);
    chk({tag, "/err"}, 32'((sel == 0) ? rsp_err0 : rsp_err3), 32'(exp_err));
    if (sel == 0) rsp_ready0 = 1'b1; else rsp_ready3 = 1'b1;
    step();
    rsp_ready0 = 1'b0;
    rsp_ready3 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid0 = 1'b0; req_valid3 = 1'b0; rsp_ready0 = 1'b0; rsp_ready3 = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) step();

    chk("rst/req_ready", 32'(req_ready0), 32'd0);
    chk("rst/rsp_valid", 32'(rsp_valid0), 32'd0);
    chk("rst/rsp_rdata", rsp_rdata0, 32'h0);
    chk("rst/rsp_err", 32'(rsp_err0), 32'd0);
    reset_n = 1'b1;

    for (int c = 1; c < DEPTH; c++) begin
      step();
      chk("clear/ready0_low", 32'(req_ready0), 32'd0);
      chk("clear/ready3_low", 32'(req_ready3), 32'd0);
    end
    step();
    chk("clear/ready0_high", 32'(req_ready0), 32'd1);
    chk("clear/ready3_high", 32'(req_ready3), 32'd1);

    xact(0, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 32'h0000_0000, 1'b0, "lw_0_after_clear");

    // Byte merge into a word.
    xact(0, 1'b1, 2'd2, 1'b0, 32'h004, 32'hA5A5_A5A5, 32'h0, 1'b0, "sw_4");
    xact(0, 1'b1, 2'd0, 1'b0, 32'h005, 32'hFFFF_FF3C, 32'h0, 1'b0, "sb_5");
    xact(0, 1'b0, 2'd2, 1'b0, 32'h004, 32'h0, 32'hA5A5_3CA5, 1'b0, "lw_4_merged");

    // Sign/zero extension.
    xact(0, 1'b1, 2'd2, 1'b0, 32'h010, 32'h8000_F080, 32'h0, 1'b0, "sw_10");
    xact(0, 1'b0, 2'd0, 1'b0, 32'h010, 32'h0, 32'hFFFF_FF80, 1'b0, "lb_10");
    xact(0, 1'b0, 2'd0, 1'b1, 32'h010, 32'h0, 32'h0000_0080, 1'b0, "lbu_10");
    xact(0, 1'b0, 2'd0, 1'b0, 32'h011, 32'h0, 32'hFFFF_FFF0, 1'b0, "lb_11");
    xact(0, 1'b0, 2'd1, 1'b0, 32'h012, 32'h0, 32'hFFFF_8000, 1'b0, "lh_12");
    xact(0, 1'b0, 2'd1, 1'b1, 32'h012, 32'h0, 32'h0000_8000, 1'b0, "lhu_12");
    xact(0, 1'b0, 2'd1, 1'b1, 32'h010, 32'h0, 32'h0000_F080, 1'b0, "lhu_10");
    xact(0, 1'b1, 2'd1, 1'b0, 32'h016, 32'h0000_BEEF, 32'h0, 1'b0, "sh_16");
    xact(0, 1'b0, 2'd2, 1'b0, 32'h014, 32'h0, 32'hBEEF_0000, 1'b0, "lw_14");

    // Last word in range.
    xact(0, 1'b1, 2'd2, 1'b0, 32'h07C, 32'hCAFE_F00D, 32'h0, 1'b0, "sw_last");
    xact(0, 1'b0, 2'd2, 1'b0, 32'h07C, 32'h0, 32'hCAFE_F00D, 1'b0, "lw_last");

    // Error responses.
    xact(0, 1'b1, 2'd2, 1'b0, 32'h022, 32'hDEAD_BEEF, 32'h0, 1'b1, "sw_misaligned");
    xact(0, 1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 32'h0000_0000, 1'b0, "lw_20_untouched");
    xact(0, 1'b0, 2'd1, 1'b0, 32'h011, 32'h0, 32'h0, 1'b1, "lh_misaligned");
    xact(0, 1'b0, 2'd2, 1'b0, 32'h080, 32'h0, 32'h0, 1'b1, "lw_out_of_range");
    xact(0, 1'b1, 2'd0, 1'b0, 32'h081, 32'h0000_0055, 32'h0, 1'b1, "sb_out_of_range");
    xact(0, 1'b0, 2'd3, 1'b0, 32'h004, 32'h0, 32'h0, 1'b1, "size3_load");
    xact(0, 1'b1, 2'd3, 1'b0, 32'h004, 32'h1111_1111, 32'h0, 1'b1, "size3_store");
    xact(0, 1'b0, 2'd2, 1'b0, 32'h004, 32'h0, 32'hA5A5_3CA5, 1'b0, "lw_4_after_size3");

    // Wait-state instance: latency and back-pressure.
    xact(1, 1'b1, 2'd2, 1'b0, 32'h044, 32'h1111_2222, 32'h0, 1'b0, "w3_sw_44");
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h044;
    chk("w3/ready_before", 32'(req_ready3), 32'd1);
    req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    req_addr = 32'h0FF;
    for (int c = 1; c <= 3; c++) begin
      chk("w3/rsp_valid_low", 32'(rsp_valid3), 32'd0);
      chk("w3/ready_low_wait", 32'(req_ready3), 32'd0);
      step();
    end
    for (int c = 0; c < 5; c++) begin
      chk("w3/rsp_valid_high", 32'(rsp_valid3), 32'd1);
      chk("w3/rdata_stable", rsp_rdata3, 32'h1111_2222);
      chk("w3/err_stable", 32'(rsp_err3), 32'd0);
      chk("w3/ready_low_resp", 32'(req_ready3), 32'd0);
      step();
    end
    rsp_ready3 = 1'b1;
    step();
    rsp_ready3 = 1'b0;
    chk("w3/rsp_valid_drop", 32'(rsp_valid3), 32'd0);
    chk("w3/ready_back", 32'(req_ready3), 32'd1);

    // Reset during WAIT of a store.
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h040; req_wdata = 32'h1234_5678;
    req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid/rsp_valid", 32'(rsp_valid3), 32'd0);
    chk("rst_mid/req_ready", 32'(req_ready3), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    for (int c = 1; c < DEPTH; c++) begin
      step();
      chk("rst_mid/sweep_ready", 32'(req_ready3), 32'd0);
      chk("rst_mid/sweep_rsp", 32'(rsp_valid3), 32'd0);
    end
    step();
    chk("rst_mid/ready_after", 32'(req_ready3), 32'd1);
    xact(1, 1'b0, 2'd2, 1'b0, 32'h040, 32'h0, 32'h0000_0000, 1'b0, "rst_mid/lw_40");
    xact(1, 1'b0, 2'd2, 1'b0, 32'h044, 32'h0, 32'h0000_0000, 1'b0, "rst_mid/lw_44_cleared");
    xact(0, 1'b0, 2'd2, 1'b0, 32'h07C, 32'h0, 32'h0000_0000, 1'b0, "rst_mid/lw_last_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
